// File: rtl/imem_boot_ctrl_if.sv
// Host program-stream channel for the instruction-memory boot controller:
// one word per valid/ready handshake, last flags the final word.
interface imem_boot_ctrl_if #(
    parameter int DW = 32
);
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
    logic          ready;

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot/load controller for the Mini-MIPS instruction memory: streams a host program
// into addresses 0.. then enables execution and hands mem_a to the fetch PC.
module imem_boot_ctrl #(
    parameter int AW    = 9,
    parameter int DW    = 32,
    parameter int DEPTH = 512
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_start,
    imem_boot_ctrl_if.slave host,
    input  logic [AW-1:0]   cpu_pc_addr,
    input  logic            cpu_halt,
    output logic [AW-1:0]   mem_a,
    output logic [DW-1:0]   mem_d,
    output logic            mem_we,
    output logic            exec,
    output logic [AW:0]     load_count,
    output logic            busy,
    output logic            err_overflow
);

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] mem_a_q;
    logic          ready_q;
    logic          accept;
    logic          at_end;

    assign accept     = (state_q == LOAD) && host.valid && ready_q;
    assign at_end     = (wr_ptr == AW'(DEPTH - 1));
    assign host.ready = ready_q;
    assign busy       = (state_q == LOAD) || (state_q == SETTLE);
    // The processor owns the address port only while running.
    assign mem_a      = (state_q == RUN) ? cpu_pc_addr : mem_a_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start) state_d = LOAD;
            LOAD: begin
                // host_last takes priority over the end-of-memory overflow.
                if (accept && host.last) state_d = SETTLE;
                else if (accept && at_end) state_d = IDLE;
            end
            SETTLE:  state_d = RUN;
            RUN:     if (cpu_halt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            mem_a_q      <= '0;
            mem_d        <= '0;
            mem_we       <= 1'b0;
            exec         <= 1'b0;
            ready_q      <= 1'b0;
            load_count   <= '0;
            err_overflow <= 1'b0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_a_q    <= wr_ptr;
                mem_d      <= host.data;
                wr_ptr     <= wr_ptr + AW'(1);
                load_count <= load_count + (AW+1)'(1);
            end
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        wr_ptr       <= '0;
                        load_count   <= '0;
                        err_overflow <= 1'b0;
                        ready_q      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept && (host.last || at_end)) ready_q <= 1'b0;
                    if (accept && !host.last && at_end) err_overflow <= 1'b1;
                end
                SETTLE: exec <= 1'b1;
                RUN: begin
                    if (cpu_halt) begin
                        exec    <= 1'b0;
                        mem_a_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Boot/load controller for the Mini-MIPS instruction memory port.
- Accepts a program stream from a host over a valid/ready handshake and writes it to consecutive instruction-memory addresses starting at 0.
- Then asserts exec and hands the memory address port to the processor's fetch address.
- Replaces hand-sequenced a/d/we/exec driving. Sits between the host interface and the Proc memory/exec inputs.

Parameters:
AW, 9, instruction memory address width (words)
DW, 32, instruction word width
DEPTH, 512, number of instruction words (2**AW)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
load_start  input  1  pulse: begin a program load (honoured only in IDLE)
host_valid  input  1  host_data holds a valid word
host_data  input  DW  instruction word from host
host_last  input  1  qualifies the final word of the program
host_ready  output  1  controller accepts a word this cycle
cpu_pc_addr  input  AW  processor fetch word address
cpu_halt  input  1  processor requests stop; return to IDLE
mem_a  output  AW  instruction memory address
mem_d  output  DW  instruction memory write data
mem_we  output  1  instruction memory write enable
exec  output  1  processor run enable
load_count  output  AW+1  words written in the current/last load
busy  output  1  high in LOAD or SETTLE
err_overflow  output  1  sticky: DEPTH words accepted without host_last

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-load or mid-run):
  - state=IDLE; wr_ptr=0.
  - mem_we=0, mem_a=0, mem_d=0, exec=0, host_ready=0, load_count=0, busy=0, err_overflow=0.
- States: IDLE, LOAD, SETTLE, RUN.
- IDLE:
  - exec=0, mem_we=0, host_ready=0.
  - load_start=1 -> LOAD. Same edge: wr_ptr=0, load_count=0, err_overflow cleared.
- LOAD:
  - host_ready=1 (registered; first high in the cycle after load_start).
  - Accept = host_valid & host_ready. On an accepting edge: mem_a<=wr_ptr, mem_d<=host_data, mem_we<=1, wr_ptr<=wr_ptr+1, load_count<=load_count+1.
  - Write latency: exactly one cycle from accept to mem_we high at the memory.
  - Non-accepting cycle: mem_we<=0; mem_a and mem_d hold.
  - Accept with host_last=1 -> SETTLE; host_ready<=0 on the same edge.
  - Accept at wr_ptr=DEPTH-1 with host_last=0 -> word written, err_overflow<=1, host_ready<=0, -> IDLE (no exec). wr_ptr wraps to 0 but is unused.
  - Accept at wr_ptr=DEPTH-1 with host_last=1: last wins -> SETTLE, no overflow.
  - load_start and cpu_halt are ignored in LOAD.
- SETTLE:
  - One cycle. The final write commits (mem_we high from the last accept); mem_we<=0; exec<=1 on exit -> RUN.
  - exec therefore rises 2 cycles after the accepting edge of the last word.
- RUN:
  - exec=1, mem_we=0, host_ready=0.
  - mem_a = cpu_pc_addr, combinational pass-through (zero latency).
  - mem_d holds the last loaded word.
  - cpu_halt=1 -> IDLE; exec<=0, mem_a returns to registered value 0.
  - load_start in RUN is ignored; the host must halt first.
- busy = (state==LOAD) | (state==SETTLE).
- load_count holds its value through SETTLE, RUN and IDLE until the next load_start.
- Simultaneous load_start and cpu_halt in RUN: halt wins; load_start is dropped and must be re-issued in IDLE.
- host_data is sampled only on accept; values at other times are don't-care.

Test Plan:
1. Load 6 words (lui $23,0; ori $23,$23,13; lui $15,0; ori $15,$15,5; sw; lw) back-to-back, last on word 6 -> mem_we pulses at mem_a=0..5 with matching mem_d; load_count=6; exec=1 exactly 2 cycles after the 6th accept; mem_a then tracks cpu_pc_addr.
2. Same program with host_valid low every other cycle -> writes only on accept cycles, mem_we low in gaps, addresses still 0..5 with no skips.
3. Stream 512 words with host_last=0 -> 512 writes (0..511), err_overflow=1, state IDLE, exec never rises; next load_start clears err_overflow.
4. Word 512 with host_last=1 -> no overflow, exec rises, load_count=512.
5. In RUN, cpu_halt=1 together with load_start -> exec falls next edge, IDLE, load ignored. A second load_start loads 2 words to addresses 0,1 -> load_count=2.
6. rst=0 asserted mid-load after 3 accepts, between clock edges -> mem_we, host_ready, exec, busy and load_count all 0 immediately; after release, IDLE waits for load_start.
